// File: rtl/ledring_ws2812_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : ledring_ws2812_ctl
//  Purpose  : Avalon-MM slave that holds a 16-pixel colour RAM and streams it
//             to a WS2812-class LED ring as single-wire NRZ bits.
//             The output pin is active-low.
//  Options  : LEDRING_BRIGHTNESS_EN adds an 8-bit global brightness scaler
//             at address 17.
//  Revision : 1.0 - initial release
// ============================================================================
module ledring_ws2812_ctl #(
    parameter int NUM_LEDS     = 16,
    parameter int T0H_CYCLES   = 20,
    parameter int T1H_CYCLES   = 40,
    parameter int BIT_CYCLES   = 63,
    parameter int LATCH_CYCLES = 2600
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    output logic        led_ring_n
);

    localparam int PIX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int BIT_W = $clog2(24);
    localparam int CYC_W = $clog2(BIT_CYCLES);
    localparam int LAT_W = $clog2(LATCH_CYCLES);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_HIGH  = 3'd2;
    localparam logic [2:0] S_LOW   = 3'd3;
    localparam logic [2:0] S_LATCH = 3'd4;

    localparam logic [PIX_W-1:0] C_PIX_LAST = PIX_W'(NUM_LEDS - 1);
    localparam logic [BIT_W-1:0] C_BIT_LAST = BIT_W'(23);
    localparam logic [CYC_W-1:0] C_T0H_LAST = CYC_W'(T0H_CYCLES - 1);
    localparam logic [CYC_W-1:0] C_T1H_LAST = CYC_W'(T1H_CYCLES - 1);
    localparam logic [CYC_W-1:0] C_CYC_LAST = CYC_W'(BIT_CYCLES - 1);
    localparam logic [LAT_W-1:0] C_LAT_LAST = LAT_W'(LATCH_CYCLES - 1);
    localparam logic [4:0]       C_ADDR_CTRL   = 5'd16;
    localparam logic [4:0]       C_ADDR_BRIGHT = 5'd17;

    logic [2:0]       state_q, state_d;
    logic             pending_q, pending_d;
    logic [PIX_W-1:0] pix_q;
    logic [BIT_W-1:0] bit_q;
    logic [CYC_W-1:0] cyc_q;
    logic [LAT_W-1:0] lat_q;
    logic [23:0]      shift_q;     // wire-order GRB bits of the pixel on the line
    logic [23:0]      nxt_q;       // prefetched wire-order bits of the next pixel
    logic [23:0]      ram_q [0:NUM_LEDS-1];
    logic [31:0]      rdata_q, rdata_d;

    logic             w_start, w_addr_pix, w_busy;
    logic             w_high_done, w_bit_done, w_last_bit, w_last_pix;
    logic             w_lat_done, w_prefetch;
    logic [PIX_W-1:0] w_fetch_addr;
    logic [23:0]      w_fetch_rgb, w_fetch_wire;
    logic             w_unused_wdata;

    assign w_start     = avs_write && (avs_address == C_ADDR_CTRL) && avs_writedata[0];
    assign w_addr_pix  = ({27'd0, avs_address} < NUM_LEDS);
    assign w_busy      = (state_q != S_IDLE);
    assign w_last_bit  = (bit_q == C_BIT_LAST);
    assign w_last_pix  = (pix_q == C_PIX_LAST);
    assign w_high_done = (state_q == S_HIGH) && (cyc_q == (shift_q[23] ? C_T1H_LAST : C_T0H_LAST));
    assign w_bit_done  = (state_q == S_LOW) && (cyc_q == C_CYC_LAST);
    assign w_lat_done  = (state_q == S_LATCH) && (lat_q == C_LAT_LAST);
    // Next pixel is fetched once, on the first cycle of the current pixel's last bit
    assign w_prefetch  = (state_q == S_HIGH) && (cyc_q == '0) && w_last_bit && !w_last_pix;
    assign w_unused_wdata = ^avs_writedata[31:24];

    // The same RAM read port serves the frame-start load and the prefetch
    assign w_fetch_addr = (state_q == S_LOAD) ? '0 : (pix_q + PIX_W'(1));
    assign w_fetch_rgb  = ram_q[w_fetch_addr];

`ifdef LEDRING_BRIGHTNESS_EN
    logic [7:0] bright_q;

    function automatic logic [7:0] f_scale(input logic [7:0] c, input logic [7:0] b);
        logic [16:0] prod;
        prod = 17'(c) * (17'(b) + 17'd1);
        return 8'(prod >> 8);
    endfunction

    assign w_fetch_wire = {f_scale(w_fetch_rgb[15:8],  bright_q),
                           f_scale(w_fetch_rgb[23:16], bright_q),
                           f_scale(w_fetch_rgb[7:0],   bright_q)};
`else
    assign w_fetch_wire = {w_fetch_rgb[15:8], w_fetch_rgb[23:16], w_fetch_rgb[7:0]};
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

    // FSM next-state and pending-request bookkeeping
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        case (state_q)
            S_IDLE: begin
                // A request that arrived in the final latch cycle restarts from here
                if (w_start || pending_q) begin
                    state_d   = S_LOAD;
                    pending_d = 1'b0;
                end
            end
            S_LOAD:  state_d = S_HIGH;
            S_HIGH:  if (w_high_done) state_d = S_LOW;
            S_LOW: begin
                if (w_bit_done) state_d = (w_last_bit && w_last_pix) ? S_LATCH : S_HIGH;
            end
            S_LATCH: begin
                if (w_lat_done) begin
                    state_d   = pending_q ? S_LOAD : S_IDLE;
                    pending_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Starts while busy collapse into a single pending frame
        if (w_start && (state_q != S_IDLE)) pending_d = 1'b1;
    end

    // FSM output: ring data is high only during the HIGH phase, pin is inverted
    always_comb begin
        led_ring_n = (state_q != S_HIGH);
    end

    // Bit/pixel/latch counters, shift register and prefetch buffer
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pix_q   <= '0;
            bit_q   <= '0;
            cyc_q   <= '0;
            lat_q   <= '0;
            shift_q <= '0;
            nxt_q   <= '0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    shift_q <= w_fetch_wire;
                    pix_q   <= '0;
                    bit_q   <= '0;
                    cyc_q   <= '0;
                end
                S_HIGH: begin
                    cyc_q <= cyc_q + CYC_W'(1);
                    if (w_prefetch) nxt_q <= w_fetch_wire;
                end
                S_LOW: begin
                    if (w_bit_done) begin
                        cyc_q <= '0;
                        if (w_last_bit) begin
                            bit_q   <= '0;
                            shift_q <= nxt_q;
                            if (!w_last_pix) pix_q <= pix_q + PIX_W'(1);
                        end else begin
                            bit_q   <= bit_q + BIT_W'(1);
                            shift_q <= {shift_q[22:0], 1'b0};
                        end
                    end else begin
                        cyc_q <= cyc_q + CYC_W'(1);
                    end
                end
                default: cyc_q <= '0;
            endcase
            lat_q <= (state_q == S_LATCH) ? (lat_q + LAT_W'(1)) : '0;
        end
    end

    // Pixel RAM write port; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (avs_write && w_addr_pix) ram_q[avs_address[PIX_W-1:0]] <= avs_writedata[23:0];
    end

`ifdef LEDRING_BRIGHTNESS_EN
    // Brightness register
    always_ff @(posedge clk) begin
        if (!reset_n) bright_q <= 8'hFF;
        else if (avs_write && (avs_address == C_ADDR_BRIGHT)) bright_q <= avs_writedata[7:0];
    end
`endif

    // Read-data mux; unmapped addresses read as zero
    always_comb begin
        rdata_d = '0;
        if (w_addr_pix) rdata_d = {8'h00, ram_q[avs_address[PIX_W-1:0]]};
        else if (avs_address == C_ADDR_CTRL) rdata_d = {30'd0, pending_q, w_busy};
`ifdef LEDRING_BRIGHTNESS_EN
        else if (avs_address == C_ADDR_BRIGHT) rdata_d = {24'd0, bright_q};
`endif
    end

    // Read data register gives a fixed one-cycle read latency
    always_ff @(posedge clk) begin
        if (!reset_n) rdata_q <= '0;
        else if (avs_read) rdata_q <= rdata_d;
    end

    assign avs_readdata = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_ledring_ws2812_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ledring_ws2812_ctl
//  Purpose  : Directed self-checking bench for ledring_ws2812_ctl. Decodes the
//             NRZ stream on led_ring_n and checks it against hand-computed
//             pixel values. Build with LEDRING_BRIGHTNESS_EN to cover scaling.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ledring_ws2812_ctl;

    logic        clk           = 1'b0;
    logic        reset_n       = 1'b0;
    logic [4:0]  avs_address   = '0;
    logic        avs_write     = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic        avs_read      = 1'b0;
    logic [31:0] avs_readdata;
    logic        led_ring_n;

    int n_tests  = 0;
    int n_fail   = 0;
    int bit_err  = 0;
    int last_hi  = 0;
    int busy_cnt = 0;
    logic cnt_en = 1'b0;

    ledring_ws2812_ctl dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .avs_address   (avs_address),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_read      (avs_read),
        .avs_readdata  (avs_readdata),
        .led_ring_n    (led_ring_n)
    );

    always #10 clk = ~clk;

    // counts cycles with busy set while status is being read every cycle
    always @(negedge clk) if (cnt_en && avs_readdata[0]) busy_cnt <= busy_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic avs_wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    task automatic avs_rd(input logic [4:0] a, output logic [31:0] d);
        @(negedge clk);
        avs_address = a; avs_read = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Called at the first negedge of a bit's high phase; returns at the next one
    task automatic rx_bit(input int max_hi, output logic b, output int lo, output int hi);
        lo = 0; hi = 0;
        while (led_ring_n == 1'b0 && lo < 200) begin lo++; @(negedge clk); end
        while (led_ring_n == 1'b1 && hi < max_hi) begin hi++; @(negedge clk); end
        b = (lo > 30);
    endtask

    task automatic rx_pixel(input bit last, output logic [23:0] px);
        logic b;
        int lo, hi;
        px = '0;
        for (int i = 0; i < 24; i++) begin
            rx_bit((last && i == 23) ? 4000 : 100, b, lo, hi);
            px = {px[22:0], b};
            if (lo != 20 && lo != 40) bit_err++;
            if (last && i == 23) last_hi = hi;
            else if (lo + hi != 63) bit_err++;
        end
    endtask

    task automatic wait_fall(input int max, input string tag);
        int n;
        n = 0;
        while (led_ring_n && n < max) begin @(negedge clk); n++; end
        chk(tag, 32'(led_ring_n), 32'd0);
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, d2;
        logic [23:0] px, px2;
        logic        b, prev;
        int          lo, hi, edges, n;
        logic [23:0] exp_d;

        // ---------------- reset ----------------
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        chk("R_led", 32'(led_ring_n), 32'd1);
        chk("R_rdata", avs_readdata, 32'd0);
        avs_rd(5'd16, d);
        chk("R_status", d, 32'd0);
        edges = 0; prev = led_ring_n;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (led_ring_n !== prev) edges++;
            prev = led_ring_n;
        end
        chk("R_quiet", edges, 0);

        // ---------------- register access ----------------
        avs_wr(5'd0, 32'h00FF0000);
        avs_wr(5'd1, 32'hAB000000);
        for (int p = 2; p < 16; p++) avs_wr(5'(p), 32'h0);
        avs_rd(5'd0, d);
        chk("M_pix0_rd", d, 32'h00FF0000);
        avs_rd(5'd1, d);
        chk("M_pix1_upper_ignored", d, 32'h0);
        avs_wr(5'd20, 32'hFFFFFFFF);
        avs_rd(5'd20, d);
        chk("M_unused_addr", d, 32'h0);

        // ---------------- frame A: first fall, bit timing, busy length ----------------
        @(negedge clk);
        avs_address = 5'd16; avs_writedata = 32'h1; avs_write = 1'b1; avs_read = 1'b1;
        cnt_en = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
        chk("A_load_led", 32'(led_ring_n), 32'd1);
        @(negedge clk);
        chk("A_first_fall", 32'(led_ring_n), 32'd0);
        bit_err = 0;
        for (int i = 0; i < 16; i++) begin
            rx_bit(100, b, lo, hi);
            chk("A_high_time", lo, (i < 8) ? 20 : 40);
            if (lo + hi != 63) bit_err++;
        end
        chk("A_period", bit_err, 0);
        chk("A_status", avs_readdata, 32'h1);
        n = 0;
        while (avs_readdata[0] !== 1'b0 && n < 40000) begin @(negedge clk); n++; end
        cnt_en = 1'b0; avs_read = 1'b0;
        chk("A_busy_cycles", busy_cnt, 16*24*63 + 2600 + 1);

        // ---------------- frame B: full decode, queued starts, relaunch gap ----------------
        for (int p = 0; p < 16; p++) avs_wr(5'(p), 32'h00A5C33C);
        avs_wr(5'd16, 32'h1);
        wait_fall(5, "B_fall");
        bit_err = 0;
        fork
            begin
                for (int p = 0; p < 16; p++) begin
                    rx_pixel(p == 15, px);
                    chk("B_pixel", px, 24'hC3A53C);
                end
            end
            begin
                repeat (200) @(negedge clk);
                avs_wr(5'd16, 32'h1);
                avs_wr(5'd16, 32'hFFFFFFFF);
                avs_wr(5'd16, 32'h1);
                avs_rd(5'd16, d);
                chk("B_status_pending", d, 32'h3);
            end
        join
        chk("B_bit_timing", bit_err, 0);
        chk("B_relaunch_gap", last_hi, 43 + 2600 + 1);

        // ---------------- frame C: queued frame, then reset mid-pixel-5 ----------------
        bit_err = 0;
        fork
            begin
                for (int p = 0; p < 5; p++) begin
                    rx_pixel(1'b0, px2);
                    chk("C_pixel", px2, 24'hC3A53C);
                end
            end
            begin
                repeat (300) @(negedge clk);
                avs_rd(5'd16, d2);
                chk("C_status_busy_only", d2, 32'h1);
            end
        join
        chk("C_bit_timing", bit_err, 0);
        repeat (10) @(negedge clk);
        chk("C_midbit_high", 32'(led_ring_n), 32'd0);
        reset_n = 1'b0;
        @(negedge clk);
        chk("C_reset_led", 32'(led_ring_n), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        avs_rd(5'd16, d);
        chk("C_reset_status", d, 32'h0);
        edges = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (led_ring_n !== 1'b1) edges++;
        end
        chk("C_reset_quiet", edges, 0);

        // ---------------- address 17 / brightness ----------------
`ifdef LEDRING_BRIGHTNESS_EN
        avs_rd(5'd17, d);
        chk("D_bright_reset", d, 32'd255);
        avs_wr(5'd17, 32'h0000007F);
        avs_rd(5'd17, d);
        chk("D_bright_rd", d, 32'h7F);
        exp_d = 24'h407F01;
`else
        avs_wr(5'd17, 32'h00000055);
        avs_rd(5'd17, d);
        chk("D_addr17_unused", d, 32'h0);
        exp_d = 24'h80FF02;
`endif
        avs_wr(5'd0, 32'h00FF8002);
        avs_wr(5'd16, 32'h1);
        wait_fall(5, "D_fall");
        rx_pixel(1'b0, px);
        chk("D_pixel0", px, exp_d);
        pulse_reset();
`ifdef LEDRING_BRIGHTNESS_EN
        avs_wr(5'd17, 32'h0);
        avs_wr(5'd0, 32'h00FFFFFF);
        avs_wr(5'd16, 32'h1);
        wait_fall(5, "D0_fall");
        rx_pixel(1'b0, px);
        chk("D_bright_zero", px, 24'h000000);
        pulse_reset();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ledring_ws2812_ctl.md
Name: ledring_ws2812_ctl

Overview:
- Avalon-MM slave peripheral in clarvi_soc that drives the display-board LED pixel ring (WS2812-class, 16 pixels) through the top-level LEDRINGn pin.
- Downstream of the CPU and interconnect. Software writes pixel colours into a local pixel RAM and triggers a refresh.
- The block serialises the frame with single-wire NRZ timing, then holds the latch gap.
- Output is active-low (led_ring_n), because the board re-inverts it before the ring.

Parameters:
NUM_LEDS, 16, pixels in ring; pixel addresses 0..NUM_LEDS-1
T0H_CYCLES, 20, clk cycles data held high for a 0 bit (0.4 us at 50 MHz)
T1H_CYCLES, 40, clk cycles data held high for a 1 bit (0.8 us)
BIT_CYCLES, 63, clk cycles per bit period (1.26 us)
LATCH_CYCLES, 2600, clk cycles data held low after the last bit (52 us)

Ports:
clk  input  1  system clock, 50 MHz
reset_n  input  1  synchronous active-low reset
avs_address  input  5  word address: 0..NUM_LEDS-1 pixel, 16 control/status, 17 brightness
avs_write  input  1  write strobe
avs_writedata  input  32  write data
avs_read  input  1  read strobe
avs_readdata  output  32  read data, fixed read latency 1
led_ring_n  output  1  inverted serial data to ring

Behaviour:
- Reset (reset_n low at a clk edge):
  - state IDLE; busy=0, pending=0, bit/pixel counters 0, avs_readdata=0.
  - led_ring_n=1 (ring data low).
  - Pixel RAM contents undefined. Brightness register resets to 255.
- Reset mid-frame aborts the frame immediately: led_ring_n=1 the next cycle, no further bits.
- Pixel format: writedata[23:16]=R, [15:8]=G, [7:0]=B; bits [31:24] are ignored.
- Wire order is G7..G0, R7..R0, B7..B0, then the next pixel. Pixel 0 is sent first.
- Register map:
  - Reads of a pixel return {8'h0, stored RGB}.
  - Read of address 16 returns {30'b0, pending, busy}.
  - Write to address 16 with writedata[0]=1 requests a refresh; other bits are ignored.
  - Addresses 18..31: writes ignored, reads return 0.
- No waitrequest. A write completes in its cycle. avs_readdata is valid on the cycle after avs_read.
- FSM states: IDLE, LOAD, HIGH, LOW, LATCH.
  - IDLE: a start write moves to LOAD next cycle and sets busy=1.
  - LOAD: fetch pixel 0 (RAM has 1-cycle read latency), then HIGH.
    - First ring-data rising edge (led_ring_n falls) occurs exactly 2 cycles after the start-write cycle.
  - HIGH: data high for T0H_CYCLES or T1H_CYCLES according to the current bit, then LOW.
  - LOW: data low for the remainder of BIT_CYCLES.
    - Then HIGH for the next bit, or LATCH after bit 23 of pixel NUM_LEDS-1.
  - Prefetch: the next pixel is fetched during the current pixel's last bit. There are no gaps between bits or pixels.
    - Total frame = NUM_LEDS*24*BIT_CYCLES cycles of bit periods.
  - LATCH: data low for LATCH_CYCLES.
    - Then, if pending=1: clear pending and go to LOAD, staying busy.
    - Otherwise: go to IDLE and clear busy.
- Start write while busy sets pending=1. Multiple start writes while busy collapse into one pending frame.
- Start write in the last LATCH cycle sets pending; it does not cause an immediate restart.
- Pixel write during a frame updates RAM immediately.
  - A pixel not yet prefetched is sent with the new value.
  - A pixel already prefetched keeps its old value for this frame.
- A simultaneous pixel write and prefetch of the same address in one cycle sends the old value.
- Counter widths are sized with $clog2 of NUM_LEDS, 24, BIT_CYCLES and LATCH_CYCLES. No counter wraps inside a frame.

Optional Feature:
- Macro LEDRING_BRIGHTNESS_EN.
- When defined:
  - Address 17 is an 8-bit brightness register: write takes writedata[7:0]; read returns {24'b0, value}.
  - Each channel c is transmitted as (c*(bright+1))>>8. 255 leaves colours unchanged; 0 gives all-zero output.
  - The scale is applied at prefetch, using the brightness value current at that cycle. No added latency.
- When undefined: address 17 behaves like an unused address, and colours are sent unscaled.

Test Plan:
- Reset with reset_n=0 for 3 cycles -> led_ring_n=1; read addr 16 returns 0; no edges on led_ring_n for 10000 cycles.
- Write pixel0=0x00FF0000, other pixels 0, then start -> led_ring_n falls 2 cycles after start.
  - First 8 bits (G=0) low-time 20 cycles; next 8 bits (R=0xFF) low-time 40 cycles.
  - busy=1 for 16*24*63+2600+1 cycles.
- Decode a full frame with all pixels 0x00A5C33C -> every pixel decodes as G=0xC3, R=0xA5, B=0x3C. Bit period exactly 63 cycles, no inter-pixel gap.
- Three start writes during a frame -> status reads 0b11; exactly one extra frame follows after the 2600-cycle latch; then status returns 0.
- Assert reset_n low mid-bit of pixel 5 -> led_ring_n=1 the next cycle; busy=0, pending=0.
- With LEDRING_BRIGHTNESS_EN: brightness=127, pixel=0x00FF8002 -> transmitted G=0x40, R=0x7F, B=0x01. Brightness=0 -> all bits are 0-codes.
